// File: rtl/button_event_if.sv
// Signal bundle between a debounced push-button source and the button_event
// decoder: the clean level in, discrete UI events out.
interface button_event_if #(
    parameter int SW = 8
);
    logic          level_in;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_press;
    logic          repeat_pulse;
    logic          held;
    logic [SW-1:0] step_count;

    // master: whoever supplies the debounced level and consumes the events
    modport master (
        output level_in,
        input  press_pulse, release_pulse, long_press, repeat_pulse, held, step_count
    );

    // slave: the button_event decoder itself
    modport slave (
        input  level_in,
        output press_pulse, release_pulse, long_press, repeat_pulse, held, step_count
    );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/release pulses, a long-press level,
// a wrapping step counter and, when BUTTON_AUTO_REPEAT_EN is defined, auto-repeat pulses.
module button_event #(
    parameter int CW            = 26,
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int SW            = 8
) (
    input logic           clk,
    input logic           reset,
    button_event_if.slave bus
);

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          long_q, long_d;
    logic          held_q, held_d;
    logic [SW-1:0] step_q, step_d;
    logic          rise, fall;

    assign rise = bus.level_in & ~prev_q;
    assign fall = ~bus.level_in & prev_q;

    // NOTE: every always_comb output gets a default before the case so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        step_d    = step_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    press_d = 1'b1;
                    step_d  = step_q + SW'(1);
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LONG: begin
                // Release wins over a coincident repeat threshold.
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (!REPEAT_EN) begin
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    step_d   = step_q + SW'(1);
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        long_d = (state_d == LONG);
        held_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= bus.level_in;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            long_q    <= long_d;
            held_q    <= held_d;
            step_q    <= step_d;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.long_press    = long_q;
    assign bus.held          = held_q;
    assign bus.step_count    = step_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4; expected
// repeat activity follows whether BUTTON_AUTO_REPEAT_EN is defined.
module tb_button_event;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int SW   = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_INC = 1;
`else
    localparam int REP_INC = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    button_event_if #(.SW(SW)) bus ();

    button_event #(
        .CW(26),
        .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP),
        .SW(SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int            checks = 0;
    int            passed = 0;
    int            failed = 0;
    int            nrep;
    logic [SW-1:0] exp_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, sample 1 time unit later, and check pulse exclusivity.
    task automatic tick();
        int n;
        @(posedge clk);
        #1;
        n = int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.repeat_pulse);
        check("pulse_exclusive", 32'(n <= 1), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_press"},   32'(bus.press_pulse),   32'd0);
        check({tag, "_release"}, 32'(bus.release_pulse), 32'd0);
        check({tag, "_repeat"},  32'(bus.repeat_pulse),  32'd0);
        check({tag, "_long"},    32'(bus.long_press),    32'd0);
        check({tag, "_held"},    32'(bus.held),          32'd0);
    endtask

    initial begin
        bus.level_in = 1'b0;
        exp_step     = '0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_step", 32'(bus.step_count), 32'd0);
        reset = 1'b1;
        tick();
        check_quiet("post_reset");

        // Short press: 3 edges high then release
        bus.level_in = 1'b1;
        tick();
        exp_step++;
        check("short_press", 32'(bus.press_pulse), 32'd1);
        check("short_held",  32'(bus.held),        32'd1);
        check("short_step",  32'(bus.step_count),  32'(exp_step));
        tick();
        check("short_press_once", 32'(bus.press_pulse), 32'd0);
        tick();
        bus.level_in = 1'b0;
        tick();
        check("short_release",  32'(bus.release_pulse), 32'd1);
        check("short_held_off", 32'(bus.held),          32'd0);
        check("short_no_long",  32'(bus.long_press),    32'd0);
        tick();
        check("short_release_once", 32'(bus.release_pulse), 32'd0);
        check("short_step_final",   32'(bus.step_count),    32'd1);

        // Long press with three repeat periods, then release
        bus.level_in = 1'b1;
        tick();
        exp_step++;
        check("long_press_pulse", 32'(bus.press_pulse), 32'd1);
        for (int i = 1; i < LONG; i++) begin
            tick();
            check("long_not_yet", 32'(bus.long_press), 32'd0);
        end
        tick();
        check("long_rise", 32'(bus.long_press), 32'd1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i < REP; i++) begin
                tick();
                check("repeat_gap", 32'(bus.repeat_pulse), 32'd0);
            end
            tick();
            exp_step += SW'(REP_INC);
            check("repeat_pulse", 32'(bus.repeat_pulse), 32'(REP_INC));
            check("repeat_step",  32'(bus.step_count),   32'(exp_step));
            check("repeat_long",  32'(bus.long_press),   32'd1);
        end
        bus.level_in = 1'b0;
        tick();
        check("long_release",     32'(bus.release_pulse), 32'd1);
        check("long_release_lp",  32'(bus.long_press),    32'd0);
        check("long_release_hld", 32'(bus.held),          32'd0);
        check("long_release_stp", 32'(bus.step_count),    32'(exp_step));
        tick();

        // Release exactly on the long threshold cycle
        bus.level_in = 1'b1;
        tick();
        exp_step++;
        for (int i = 1; i < LONG; i++) tick();
        bus.level_in = 1'b0;
        tick();
        check("thr_release",   32'(bus.release_pulse), 32'd1);
        check("thr_no_long",   32'(bus.long_press),    32'd0);
        tick();
        check("thr_no_long_after", 32'(bus.long_press), 32'd0);
        check("thr_step",      32'(bus.step_count),    32'(exp_step));

        // Release exactly on the repeat threshold cycle
        bus.level_in = 1'b1;
        tick();
        exp_step++;
        for (int i = 0; i < LONG; i++) tick();
        check("rthr_long", 32'(bus.long_press), 32'd1);
        for (int i = 1; i < REP; i++) tick();
        bus.level_in = 1'b0;
        tick();
        check("rthr_release",   32'(bus.release_pulse), 32'd1);
        check("rthr_no_repeat", 32'(bus.repeat_pulse),  32'd0);
        check("rthr_step",      32'(bus.step_count),    32'(exp_step));
        tick();

        // Button held through reset release produces no press
        reset        = 1'b0;
        bus.level_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_quiet("held_through_reset");
        tick();
        check_quiet("held_through_reset2");
        bus.level_in = 1'b0;
        tick();
        check("held_drop_no_release", 32'(bus.release_pulse), 32'd0);
        bus.level_in = 1'b1;
        tick();
        check("held_repress", 32'(bus.press_pulse), 32'd1);
        check("held_step",    32'(bus.step_count),  32'd1);
        bus.level_in = 1'b0;
        tick();
        tick();

        // 256 single-cycle taps from a fresh reset wrap step_count to 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            bus.level_in = 1'b1;
            tick();
            check("tap_press", 32'(bus.press_pulse), 32'd1);
            bus.level_in = 1'b0;
            tick();
            check("tap_release", 32'(bus.release_pulse), 32'd1);
            tick();
        end
        check("tap_wrap", 32'(bus.step_count), 32'd0);

        // Hold 20 edges past the press, then reset in the middle of LONG
        nrep = 0;
        bus.level_in = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            nrep += int'(bus.repeat_pulse);
        end
        check("hold20_long",    32'(bus.long_press), 32'd1);
        check("hold20_repeats", 32'(nrep),           32'(3 * REP_INC));
        check("hold20_step",    32'(bus.step_count), 32'(1 + 3 * REP_INC));
        reset = 1'b0;
        tick();
        check_quiet("midlong_reset");
        check("midlong_reset_step", 32'(bus.step_count), 32'd0);
        reset = 1'b1;
        tick();
        check_quiet("midlong_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the push-button debouncer. Consumes its clean, debounced level and turns it into discrete UI events for the VGA control logic (cursor/colour/menu stepping).
- Event outputs:
  - single-cycle press pulse
  - single-cycle release pulse
  - long-press level
  - optional auto-repeat pulses while the button is held
  - wrapping step counter

Parameters:
- CW, 26, width of the internal hold/repeat counter.
- LONG_CYCLES, 25_000_000, cycles held in PRESSED before long-press is declared (≥2, < 2^CW).
- REPEAT_CYCLES, 5_000_000, period of repeat pulses once long-press is active (≥2, < 2^CW).
- SW, 8, width of step_count.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, synchronous, active-low reset (0 = reset, sampled on rising clk edge).
- level_in, input, 1, debounced button level, 1 = pressed.
- press_pulse, output, 1, one-cycle pulse on accepted press.
- release_pulse, output, 1, one-cycle pulse on release.
- long_press, output, 1, high while button held past LONG_CYCLES.
- repeat_pulse, output, 1, one-cycle auto-repeat pulse (see Optional Feature).
- held, output, 1, high in PRESSED or LONG.
- step_count, output, SW, count of press_pulse plus repeat_pulse events, wraps.

Behaviour:
- **Reset** (reset=0 at an edge):
  - state=IDLE, cnt=0
  - all pulse outputs=0, long_press=0, held=0, step_count=0
  - prev sample register = 1
- **Edge detection:**
  - prev holds level_in from the previous edge.
  - rise = level_in & ~prev; fall = ~level_in & prev.
  - prev resets to 1, so a button already held through reset release produces no press. It must go low and then high again.
- **Registered outputs, latency 1:** an event detected with level_in sampled at edge N appears on the outputs after edge N and lasts exactly one cycle (pulses).
- **IDLE:**
  - cnt=0.
  - On rise: press_pulse=1, step_count+1, state→PRESSED, held=1.
  - level_in high without a rise (post-reset hold) keeps IDLE.
- **PRESSED:**
  - On fall: release_pulse=1, held=0, cnt=0, →IDLE.
  - Else if cnt==LONG_CYCLES-1: long_press=1, cnt=0, →LONG.
  - Else cnt+1.
  - long_press therefore rises after LONG_CYCLES edges in PRESSED.
- **LONG:**
  - On fall: release_pulse=1, long_press=0, held=0, cnt=0, →IDLE.
  - Else, with AUTO_REPEAT_EN: if cnt==REPEAT_CYCLES-1, then repeat_pulse=1, step_count+1, cnt=0; else cnt+1.
- **Simultaneous events:** fall takes priority over the long threshold and the repeat threshold in the same cycle. No long_press and no repeat_pulse are issued on the release cycle.
- **Single-cycle tap:** a 1-cycle high level_in gives press_pulse, then release_pulse on the next cycle. step_count increments once.
- **step_count:** wraps 2^SW-1 → 0 with no flag.
- **Reset mid-operation:** abort immediately to reset values. No release_pulse is generated.
- **Mutual exclusion:** press_pulse, release_pulse and repeat_pulse are never high in the same cycle.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- **Defined:** LONG state generates repeat_pulse every REPEAT_CYCLES cycles and counts each pulse in step_count.
- **Undefined:**
  - repeat_pulse is tied 0.
  - cnt holds at 0 in LONG.
  - step_count counts presses only.
  - long_press, held and release behave identically.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, SW=8, macro defined unless stated):
- Reset, then level_in 0→1 held 3 cycles, then 0 → press_pulse one cycle after the rise. release_pulse one cycle after the fall. step_count=1, long_press never 1.
- Hold level_in high 8 cycles → long_press rises after the 8th PRESSED edge. repeat_pulse at LONG+4, +8, +12. Releasing after 3 repeats → release_pulse, long_press=0, step_count=4.
- Release on exactly the cycle cnt==7 in PRESSED → release_pulse only, long_press stays 0. Release on the repeat-threshold cycle → no repeat_pulse.
- level_in=1 while reset=0, then reset→1 with level held → no press_pulse. Drop then raise → exactly one press_pulse.
- 256 single-cycle taps separated by idle cycles → step_count wraps to 0. No two pulse outputs are ever coincident.
- Macro undefined: hold 20 cycles → long_press=1, repeat_pulse always 0, step_count=1. Assert reset mid-LONG → all outputs 0 next cycle, no release_pulse.
